// File: rtl/mem_dump_sequencer.sv
// UART-driven memory dump: receives {CMD_READ, start address, count} and streams
// count bytes of memory (count 0 = 256) back through the UART transmitter.
module mem_dump_sequencer #(
   parameter logic [7:0]  CMD_READ   = 8'h52,
   parameter logic [15:0] RX_TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_data_rx,
   input  logic [7:0] data_rx,
   input  logic       busy,
   input  logic       block,
   output logic       new_data_tx,
   output logic [7:0] data_tx,
   output logic [7:0] addr,
   input  logic [7:0] data,
   output logic       active
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GET_ADDR  = 3'd1,
      GET_CNT   = 3'd2,
      FETCH     = 3'd3,
      WAIT_DATA = 3'd4,
      SEND      = 3'd5,
      WAIT_TX   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  data_tx_q, data_tx_d;
   logic [8:0]  remaining_q, remaining_d;
   logic [15:0] timer_q, timer_d;
   logic        active_q, active_d;
   logic        rx_mute_q, rx_mute_d;

   logic        rx_timeout;
   logic        tx_ready;
   logic        last_byte;
   logic        cmd_seen;

   assign rx_timeout = (timer_q == (RX_TIMEOUT - 16'd1));
   assign tx_ready   = !busy && !block;
   assign last_byte  = (remaining_q <= 9'd1);
   // rx_mute_q is high only on the first cycle back in IDLE, so a strobe landing
   // exactly as a frame ends or times out cannot open a new frame.
   assign cmd_seen   = new_data_rx && !rx_mute_q && (data_rx == CMD_READ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= 8'h00;
         data_tx_q   <= 8'h00;
         remaining_q <= 9'd0;
         timer_q     <= 16'd0;
         active_q    <= 1'b0;
         rx_mute_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_tx_q   <= data_tx_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         active_q    <= active_d;
         rx_mute_q   <= rx_mute_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_seen) state_d = GET_ADDR;
         end
         GET_ADDR: begin
            if (new_data_rx)     state_d = GET_CNT;
            else if (rx_timeout) state_d = IDLE;
         end
         GET_CNT: begin
            if (new_data_rx)     state_d = FETCH;
            else if (rx_timeout) state_d = IDLE;
         end
         FETCH:     state_d = WAIT_DATA;
         WAIT_DATA: state_d = SEND;
         SEND: begin
            if (tx_ready) state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (last_byte) state_d = IDLE;
            else           state_d = FETCH;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      data_tx_d   = data_tx_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      active_d    = active_q;
      rx_mute_d   = 1'b0;
      new_data_tx = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = 16'd0;
         end
         GET_ADDR: begin
            if (new_data_rx) begin
               addr_d  = data_rx;
               timer_d = 16'd0;
            end else if (rx_timeout) begin
               timer_d   = 16'd0;
               rx_mute_d = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         GET_CNT: begin
            if (new_data_rx) begin
               remaining_d = (data_rx == 8'h00) ? 9'd256 : {1'b0, data_rx};
               active_d    = 1'b1;
               timer_d     = 16'd0;
            end else if (rx_timeout) begin
               timer_d   = 16'd0;
               rx_mute_d = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         WAIT_DATA: begin
            // Memory has had a full cycle since addr settled, so data is valid here.
            data_tx_d = data;
         end
         SEND: begin
            new_data_tx = tx_ready;
         end
         WAIT_TX: begin
            remaining_d = remaining_q - 9'd1;
            addr_d      = addr_q + 8'd1;
            if (last_byte) begin
               active_d  = 1'b0;
               rx_mute_d = 1'b1;
            end
         end
         default: begin
            timer_d = 16'd0;
         end
      endcase
   end

   assign addr    = addr_q;
   assign data_tx = data_tx_q;
   assign active  = active_q;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Bench for mem_dump_sequencer: memory mem[i] = i ^ A5, directed frames plus
// randomized frames with random busy/block, checked against a frame-level model.
module tb_mem_dump_sequencer;

   localparam logic [7:0]  CMD = 8'h52;
   localparam int          RXT = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       new_data_rx = 1'b0;
   logic [7:0] data_rx = 8'h00;
   logic       busy = 1'b0;
   logic       block = 1'b0;
   logic       new_data_tx;
   logic [7:0] data_tx;
   logic [7:0] addr;
   logic [7:0] data;
   logic       active;

   int vec = 0;
   int miscmp = 0;

   logic [7:0] tx_q[$];
   logic [7:0] ad_q[$];
   int  viol = 0;
   int  cyc = 0;
   int  last_cyc = 0;
   bit  have_last = 1'b0;
   bit  rand_en = 1'b0;

   mem_dump_sequencer #(
      .CMD_READ   (CMD),
      .RX_TIMEOUT (16'(RXT))
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .new_data_rx (new_data_rx),
      .data_rx     (data_rx),
      .busy        (busy),
      .block       (block),
      .new_data_tx (new_data_tx),
      .data_tx     (data_tx),
      .addr        (addr),
      .data        (data),
      .active      (active)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory model.
   always @(posedge clk) data <= addr ^ 8'hA5;

   // Transmit monitor: logs every pulse and flags handshake rule violations.
   always @(negedge clk) begin
      if (rst) begin
         have_last = 1'b0;
      end else begin
         cyc = cyc + 1;
         if (new_data_tx === 1'b1) begin
            tx_q.push_back(data_tx);
            ad_q.push_back(addr);
            if (busy || block) viol = viol + 1;
            if (have_last && (cyc - last_cyc) < 4) viol = viol + 1;
            have_last = 1'b1;
            last_cyc  = cyc;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_en) begin
            busy  = ($urandom_range(0, 2) == 0);
            block = ($urandom_range(0, 7) == 0);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec = vec + 1;
      assert (obs === exp) else begin
         miscmp = miscmp + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   // Called just after a rising edge; strobes one byte for exactly one cycle.
   task automatic send_byte(input logic [7:0] b);
      data_rx     = b;
      new_data_rx = 1'b1;
      @(posedge clk);
      #1;
      new_data_rx = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] a, input logic [7:0] c);
      @(posedge clk);
      #1;
      tx_q.delete();
      ad_q.delete();
      send_byte(CMD);
      send_byte(a);
      send_byte(c);
      chk("active_rise", active, 1);
   endtask

   task automatic finish_frame(input logic [7:0] a, input logic [7:0] c);
      int n;
      logic [7:0] ea;
      n = (c == 8'h00) ? 256 : int'(c);
      for (int i = 0; i < n * 80 + 200; i++) begin
         wait_neg();
         if (!active) break;
      end
      chk("active_fall", active, 0);
      chk("pulse_count", tx_q.size(), n);
      for (int k = 0; k < n; k++) begin
         ea = a + 8'(k);
         if (k < tx_q.size()) begin
            chk("tx_byte", tx_q[k], ea ^ 8'hA5);
            chk("tx_addr", ad_q[k], ea);
         end
      end
      ea = a + 8'(n);
      chk("final_addr", addr, ea);
      chk("handshake_rules", viol, 0);
   endtask

   task automatic wait_pulses(input int n);
      for (int i = 0; i < 400 && tx_q.size() < n; i++) wait_neg();
      chk("pulse_reached", tx_q.size(), n);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rc;

      // Reset values
      wait_neg();
      chk("rst_new_data_tx", new_data_tx, 0);
      chk("rst_data_tx", data_tx, 8'h00);
      chk("rst_addr", addr, 8'h00);
      chk("rst_active", active, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic 3-byte dump
      start_frame(8'h10, 8'h03);
      finish_frame(8'h10, 8'h03);
      if (tx_q.size() == 3) begin
         chk("byte0_lit", tx_q[0], 8'hB5);
         chk("byte1_lit", tx_q[1], 8'hB4);
         chk("byte2_lit", tx_q[2], 8'hB7);
      end

      // Address wrap
      start_frame(8'hFE, 8'h03);
      finish_frame(8'hFE, 8'h03);

      // Count 0 = 256 bytes
      start_frame(8'h00, 8'h00);
      finish_frame(8'h00, 8'h00);

      // busy then block held 20 cycles
      start_frame(8'h20, 8'h05);
      wait_pulses(1);
      @(posedge clk);
      #1;
      busy = 1'b1;
      idle_cycles(20);
      chk("no_pulse_busy", tx_q.size(), 1);
      busy = 1'b0;
      wait_neg();
      chk("pulse_after_busy", new_data_tx, 1);
      chk("data_after_busy", data_tx, 8'h21 ^ 8'hA5);
      @(posedge clk);
      #1;
      block = 1'b1;
      idle_cycles(20);
      chk("no_pulse_block", tx_q.size(), 2);
      block = 1'b0;
      wait_neg();
      chk("pulse_after_block", new_data_tx, 1);
      chk("data_after_block", data_tx, 8'h22 ^ 8'hA5);
      finish_frame(8'h20, 8'h05);

      // Timeout, then non-command byte in IDLE
      @(posedge clk);
      #1;
      tx_q.delete();
      send_byte(CMD);
      send_byte(8'h10);
      idle_cycles(RXT);
      send_byte(8'h03);
      chk("timeout_active", active, 0);
      send_byte(8'h41);
      send_byte(8'h10);
      send_byte(8'h02);
      idle_cycles(30);
      chk("timeout_no_tx", tx_q.size(), 0);
      chk("timeout_active2", active, 0);

      // Count byte one cycle before timeout is still accepted
      @(posedge clk);
      #1;
      tx_q.delete();
      ad_q.delete();
      send_byte(CMD);
      send_byte(8'h30);
      idle_cycles(RXT - 1);
      send_byte(8'h03);
      chk("late_cnt_active", active, 1);
      finish_frame(8'h30, 8'h03);

      // Command strobe on the first IDLE cycle after a dump is ignored
      start_frame(8'h40, 8'h02);
      finish_frame(8'h40, 8'h02);
      tx_q.delete();
      data_rx     = CMD;
      new_data_rx = 1'b1;
      @(posedge clk);
      #1;
      new_data_rx = 1'b0;
      send_byte(8'h10);
      send_byte(8'h02);
      idle_cycles(30);
      chk("reentry_no_tx", tx_q.size(), 0);
      chk("reentry_active", active, 0);

      // Command bytes mid-dump do not restart the frame
      start_frame(8'h60, 8'h04);
      wait_pulses(1);
      @(posedge clk);
      #1;
      send_byte(CMD);
      send_byte(8'h70);
      send_byte(8'h01);
      finish_frame(8'h60, 8'h04);
      idle_cycles(30);
      chk("mid_cmd_no_extra", tx_q.size(), 4);

      // Reset between second and third pulse
      start_frame(8'h80, 8'h05);
      wait_pulses(2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_neg();
      chk("mid_rst_new_data_tx", new_data_tx, 0);
      chk("mid_rst_data_tx", data_tx, 8'h00);
      chk("mid_rst_addr", addr, 8'h00);
      chk("mid_rst_active", active, 0);
      idle_cycles(3);
      rst = 1'b0;
      idle_cycles(40);
      chk("post_rst_no_tx", tx_q.size(), 2);
      chk("post_rst_active", active, 0);
      start_frame(8'h90, 8'h03);
      finish_frame(8'h90, 8'h03);

      // Randomized frames with random busy/block
      rand_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         ra = 8'($urandom_range(0, 255));
         if (f == 0) ra = 8'hFA;
         rc = 8'($urandom_range(1, 12));
         start_frame(ra, rc);
         finish_frame(ra, rc);
      end
      rand_en = 1'b0;
      @(posedge clk);
      #2;
      busy  = 1'b0;
      block = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule

// File: doc/mem_dump_sequencer.md
MEM_DUMP_SEQUENCER -- requirements
Module: mem_dump_sequencer

Interface
REQ-001 Parameter CMD_READ, default 8'h52, is the command byte that opens a dump frame.
REQ-002 Parameter RX_TIMEOUT, default 16'd50000, is the maximum number of clk cycles allowed between frame bytes.
REQ-003 One clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 new_data_rx  in  1  one-cycle strobe: data_rx holds a received byte.
REQ-007 data_rx  in  8  received UART byte.
REQ-008 busy  in  1  UART transmitter is shifting a byte.
REQ-009 block  in  1  UART transmit hold-off; tie to 0 when unused.
REQ-010 new_data_tx  out  1  one-cycle strobe: transmit data_tx.
REQ-011 data_tx  out  8  byte to transmit.
REQ-012 addr  out  8  memory read address, registered.
REQ-013 data  in  8  memory read data, valid one cycle after addr changes.
REQ-014 active  out  1  high from frame acceptance until the last byte is handed to the UART.

Function
REQ-015 Frame format: byte0 = CMD_READ, byte1 = start address, byte2 = count; count 0 means 256 bytes.
REQ-016 States: IDLE, GET_ADDR, GET_CNT, FETCH, WAIT_DATA, SEND, WAIT_TX.
REQ-017 IDLE: on new_data_rx with data_rx == CMD_READ, go to GET_ADDR; any other byte is ignored and the block stays in IDLE.
REQ-018 GET_ADDR: on new_data_rx, latch the address into addr and go to GET_CNT.
REQ-019 GET_CNT: on new_data_rx, latch the count into a 9-bit remaining counter (0 loads 256), set active, and go to FETCH.
REQ-020 In GET_ADDR and GET_CNT, a 16-bit timer counts cycles without new_data_rx; on reaching RX_TIMEOUT, return to IDLE with no output activity.
REQ-021 FETCH lasts one cycle, then goes to WAIT_DATA; WAIT_DATA samples data into data_tx at the end of its cycle, then goes to SEND.
REQ-022 SEND: when busy == 0 and block == 0, pulse new_data_tx for exactly one cycle and go to WAIT_TX; otherwise hold in SEND.
REQ-023 WAIT_TX holds for one guard cycle, then decrements remaining and increments addr modulo 256 (8'hFF wraps to 8'h00).
REQ-024 WAIT_TX next state: FETCH if remaining > 0 after the decrement; otherwise IDLE with active cleared in the same cycle.
REQ-025 data_tx stays stable from each new_data_tx pulse until the next WAIT_DATA sample.
REQ-026 new_data_rx is ignored in FETCH, WAIT_DATA, SEND and WAIT_TX; a CMD_READ byte arriving mid-dump does not restart the frame.
REQ-027 Consecutive new_data_tx pulses are at least 4 cycles apart, and a pulse is never issued while busy or block is high.
REQ-028 A new_data_rx strobe on the cycle the block re-enters IDLE is ignored.

Reset
REQ-029 While rst is high: state = IDLE, new_data_tx = 0, data_tx = 8'h00, addr = 8'h00, active = 0, remaining = 0, timer = 0.
REQ-030 Reset asserted mid-dump aborts immediately; no new_data_tx pulse occurs until a new full frame is received after reset deasserts.

Verification
REQ-031 Memory model mem[i] = i ^ 8'hA5, busy = 0; rx 52,10,03 -> three tx pulses carrying B5,B4,B7; active falls after the third pulse.
REQ-032 rx 52,FE,03 -> addr sequence FE,FF,00; tx bytes 5B,5A,A5 (wrap-around).
REQ-033 rx 52,00,00 -> exactly 256 tx pulses, addr ends at 00, then IDLE.
REQ-034 Hold busy = 1 (or block = 1) for 20 cycles during a dump -> no pulse while it is high; the pending byte is sent the cycle after it clears, unchanged.
REQ-035 rx 52,10, then idle for RX_TIMEOUT cycles, then rx 03 -> no tx activity and active stays 0; rx 41 in IDLE -> ignored.
REQ-036 Assert rst between the second and third tx pulse of a 5-byte dump -> outputs at reset values, no further pulses; a new frame then works normally.
